// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter widths, sync bundle type and game state encodings.
// Used by vga_sync_gen and the drawing layers.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam logic H_POL_DEF = 1'b1;
   localparam logic V_POL_DEF = 1'b1;

   localparam int X_W     = 11;
   localparam int Y_W     = 10;
   localparam int FRAME_W = 8;

   localparam int H_TOTAL_MAX = 2 ** X_W;
   localparam int V_TOTAL_MAX = 2 ** Y_W;

   typedef enum logic [3:0] {
      STATE_LOGO  = 4'b0000,
      STATE_TITLE = 4'b0001,
      STATE_PLAY  = 4'b0010,
      STATE_OVER  = 4'b0011
   } game_state_t;

   // Signals that travel together and may be retimed as one bundle.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// One-cycle retiming register for the sync bundle, synchronously reset to a chosen idle value.
module vga_sync_delay #(
   parameter int           W       = 3,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         vga_clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge vga_clk) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter and sync generator; all outputs registered, decoded from the next count.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by one extra pixel clock.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic H_POL    = H_POL_DEF,
   parameter logic V_POL    = V_POL_DEF
) (
   input  logic               vga_clk,
   input  logic               rst,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > H_TOTAL_MAX || V_TOTAL > V_TOTAL_MAX) begin : g_width_check
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the x/y counter widths");
   end

   // One spare bit so sync end positions equal to the total still compare correctly.
   localparam int XE = X_W + 1;
   localparam int YE = Y_W + 1;

   localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [XE-1:0]  X_ACT    = XE'(H_ACTIVE);
   localparam logic [XE-1:0]  HS_START = XE'(H_ACTIVE + H_FP);
   localparam logic [XE-1:0]  HS_END   = XE'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YE-1:0]  Y_ACT    = YE'(V_ACTIVE);
   localparam logic [YE-1:0]  VS_START = YE'(V_ACTIVE + V_FP);
   localparam logic [YE-1:0]  VS_END   = YE'(V_ACTIVE + V_FP + V_SYNC);

   localparam sync_t SYNC_IDLE = '{hsync: ~H_POL, vsync: ~V_POL, video_on: 1'b0};

   logic [X_W-1:0]     x_next;
   logic [Y_W-1:0]     y_next;
   logic [FRAME_W-1:0] frame_cnt_next;
   logic               x_wrap;
   logic               y_wrap;
   logic               line_start_next;
   logic               frame_start_next;
   sync_t              sync_next;
   sync_t              sync_q;

   always_comb begin
      x_wrap         = (x == X_LAST);
      y_wrap         = (y == Y_LAST);
      x_next         = x_wrap ? '0 : x + 1'b1;
      y_next         = y;
      frame_cnt_next = frame_cnt;
      if (x_wrap) begin
         y_next = y_wrap ? '0 : y + 1'b1;
         if (y_wrap) frame_cnt_next = frame_cnt + 1'b1;
      end

      // Decode from the next count so registered flags line up with the registered x/y.
      sync_next.video_on = ({1'b0, x_next} < X_ACT) && ({1'b0, y_next} < Y_ACT);
      sync_next.hsync    = (({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END)) ? H_POL : ~H_POL;
      sync_next.vsync    = (({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END)) ? V_POL : ~V_POL;
      line_start_next    = (x_next == '0);
      frame_start_next   = (x_next == '0) && (y_next == '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
   // reset is synchronous, so it is simply the highest-priority branch inside the clocked block.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         frame_cnt   <= '0;
         sync_q      <= SYNC_IDLE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= x_next;
         y           <= y_next;
         frame_cnt   <= frame_cnt_next;
         sync_q      <= sync_next;
         line_start  <= line_start_next;
         frame_start <= frame_start_next;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   sync_t sync_dly;

   vga_sync_delay #(
      .W       ($bits(sync_t)),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .vga_clk (vga_clk),
      .rst     (rst),
      .d       (sync_q),
      .q       (sync_dly)
   );

   assign hsync    = sync_dly.hsync;
   assign vsync    = sync_dly.vsync;
   assign video_on = sync_dly.video_on;
`else
   assign hsync    = sync_q.hsync;
   assign vsync    = sync_q.vsync;
   assign video_on = sync_q.video_on;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, shrunk instance for frame timing,
// both checked every cycle against a raster-position model.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
   localparam int DLY = 1;
`else
   localparam int DLY = 0;
`endif

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        hsync;
      logic        vsync;
      logic        video_on;
      logic        line_start;
      logic        frame_start;
      logic [7:0]  frame_cnt;
   } outs_t;

   logic vga_clk = 1'b0;
   logic rst     = 1'b1;

   logic [10:0] a_x, b_x;
   logic [9:0]  a_y, b_y;
   logic        a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
   logic        b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
   logic [7:0]  a_frame_cnt, b_frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 vga_clk = ~vga_clk;

   vga_sync_gen u_dut_std (
      .vga_clk     (vga_clk),
      .rst         (rst),
      .x           (a_x),
      .y           (a_y),
      .hsync       (a_hsync),
      .vsync       (a_vsync),
      .video_on    (a_video_on),
      .line_start  (a_line_start),
      .frame_start (a_frame_start),
      .frame_cnt   (a_frame_cnt)
   );

   // 20 x 10 raster with active-low syncs: 200 cycles per frame.
   vga_sync_gen #(
      .H_ACTIVE (12), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .H_POL    (1'b0), .V_POL (1'b0)
   ) u_dut_small (
      .vga_clk     (vga_clk),
      .rst         (rst),
      .x           (b_x),
      .y           (b_y),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .video_on    (b_video_on),
      .line_start  (b_line_start),
      .frame_start (b_frame_start),
      .frame_cnt   (b_frame_cnt)
   );

   // Model state: p counts edges since reset was released (0 while held in reset).
   longint p         = 0;
   bit     rst_state = 1'b1;
   bit     model_ok  = 1'b0;

   always @(posedge vga_clk) begin
      if (rst) begin
         p         = 0;
         rst_state = 1'b1;
      end else begin
         p         = p + 1;
         rst_state = 1'b0;
      end
      model_ok = 1'b1;
   end

   function automatic outs_t model_outs(int ha, int hfp, int hs, int hbp,
                                        int va, int vfp, int vs, int vbp,
                                        bit hpol, bit vpol, bit in_rst, longint pos);
      outs_t  o;
      longint ht, vt, line, q, qx, qy;
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      o = '0;
      o.hsync = ~hpol;
      o.vsync = ~vpol;
      if (in_rst) return o;
      line          = pos / ht;
      o.x           = 11'(pos % ht);
      o.y           = 10'(line % vt);
      o.frame_cnt   = 8'((line / vt) % 256);
      o.line_start  = (pos % ht) == 0;
      o.frame_start = o.line_start && ((line % vt) == 0);
      // Sync flags reflect raster position q; position 0 is the reset state, which is idle.
      q = pos - DLY;
      if (q > 0) begin
         qx = q % ht;
         qy = (q / ht) % vt;
         o.video_on = (qx < ha) && (qy < va);
         o.hsync    = (qx >= ha + hfp && qx < ha + hfp + hs) ? hpol : ~hpol;
         o.vsync    = (qy >= va + vfp && qy < va + vfp + vs) ? vpol : ~vpol;
      end
      return o;
   endfunction

   function automatic string fmt(outs_t o);
      return $sformatf("x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                       o.x, o.y, o.hsync, o.vsync, o.video_on, o.line_start, o.frame_start, o.frame_cnt);
   endfunction

   task automatic check_outs(string name, outs_t got, outs_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s p=%0d: got %s, expected %s", name, p, fmt(got), fmt(exp));
      end
   endtask

   task automatic check(string name, longint got, longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   always @(negedge vga_clk) begin
      if (model_ok) begin
         check_outs("std_cycle",
                    {a_x, a_y, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_frame_cnt},
                    model_outs(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, rst_state, p));
         check_outs("small_cycle",
                    {b_x, b_y, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start, b_frame_cnt},
                    model_outs(12, 2, 3, 3, 6, 1, 2, 1, 1'b0, 1'b0, rst_state, p));
      end
   end

   // Event statistics used for the hand-computed expectations.
   int hs_cnt = 0, vo_cnt = 0, hs_rise_x = -1, vo_fall_x = -1;
   int ls_cnt = 0, ls_x = -1, ls_y = -1;
   int vs_cnt = 0, fs_cnt = 0, fs_fc = -1;
   int fc_before = -1, fc_after = -1, fs_at_wrap = -1;
   bit prev_hs = 1'b0, prev_vo = 1'b0;

   always @(negedge vga_clk) begin
      if (model_ok && !rst_state) begin
         if (p >= 1056 && p < 2112) begin
            if (a_hsync) hs_cnt++;
            if (a_video_on) vo_cnt++;
            if (a_hsync && !prev_hs && hs_rise_x < 0) hs_rise_x = int'(a_x);
            if (!a_video_on && prev_vo && vo_fall_x < 0) vo_fall_x = int'(a_x);
         end
         if (p >= 1 && p <= 1056 && a_line_start) begin
            ls_cnt++;
            ls_x = int'(a_x);
            ls_y = int'(a_y);
         end
         if (p >= 1 && p <= 199 && b_vsync == 1'b0) vs_cnt++;
         if (p >= 1 && p <= 200 && b_frame_start) begin
            fs_cnt++;
            fs_fc = int'(b_frame_cnt);
         end
         if (p == 51199) fc_before = int'(b_frame_cnt);
         if (p == 51200) begin
            fc_after   = int'(b_frame_cnt);
            fs_at_wrap = int'(b_frame_start);
         end
      end
      prev_hs = a_hsync;
      prev_vo = a_video_on;
   end

   task automatic step(int n);
      repeat (n) @(negedge vga_clk);
   endtask

   initial begin
      rst = 1'b1;
      step(3);
      check("reset_std_xy",    {a_x, a_y}, 0);
      check("reset_std_flags", {a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start}, 0);
      check("reset_std_fc",    a_frame_cnt, 0);
      check("reset_small_sync", {b_hsync, b_vsync, b_video_on}, 3'b110);

      #1 rst = 1'b0;
      step(1);
      check("first_edge_x",   a_x, 1);
      check("first_edge_y",   a_y, 0);
      check("first_edge_von", a_video_on, (DLY == 0) ? 1 : 0);
      check("first_edge_ls",  a_line_start, 0);

      step(51286);
      check("pre_reset_small_x", b_x, 7);
      check("pre_reset_small_y", b_y, 4);
      #1 rst = 1'b1;
      step(1);
      check("mid_reset_small_xy",   {b_x, b_y}, 0);
      check("mid_reset_small_sync", {b_hsync, b_vsync, b_video_on}, 3'b110);
      check("mid_reset_small_fc",   b_frame_cnt, 0);
      check("mid_reset_std_sync",   {a_hsync, a_vsync, a_video_on}, 0);
      #1 rst = 1'b0;
      step(3);
      check("post_reset_small_x", b_x, 3);

      check("line_start_count", ls_cnt, 1);
      check("line_start_x",     ls_x, 0);
      check("line_start_y",     ls_y, 1);
      check("hsync_cycles",     hs_cnt, 128);
      check("hsync_rise_x",     hs_rise_x, 840 + DLY);
      check("video_on_cycles",  vo_cnt, 800);
      check("video_on_fall_x",  vo_fall_x, 800 + DLY);
      check("vsync_cycles",     vs_cnt, 40);
      check("frame_start_count", fs_cnt, 1);
      check("frame_cnt_first",  fs_fc, 1);
      check("frame_cnt_255",    fc_before, 255);
      check("frame_cnt_wrap",   fc_after, 0);
      check("frame_start_wrap", fs_at_wrap, 1);

      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
